// File: rtl/filter_arbiter_rr_pkg.sv
// Shared constants for the pair-filter to force-pipeline merge path.
// PAIR_WIDTH must match the filter output and force-pipeline input record widths.
package filter_arbiter_rr_pkg;

    localparam int unsigned PAIR_WIDTH     = 96;
    localparam int unsigned NUM_FILTER_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = PAIR_WIDTH;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned AF_MARGIN_DEF  = 2;

endpackage

// File: rtl/filter_buffer_fifo.sv
// Per-channel first-word-fall-through FIFO with a registered almost_full flag.
// A push while full is ignored; a pop while empty is ignored.
module filter_buffer_fifo
    import filter_arbiter_rr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AF_MARGIN  = AF_MARGIN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        pop,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic [CW-1:0]         count_nxt;

    // Flags come from the registered count only, so a simultaneous pop never frees a slot early.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count       <= count_nxt;
            almost_full <= (count_nxt >= CW'(FIFO_DEPTH - AF_MARGIN));
        end
    end

    // Storage is not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/filter_arbiter_rr.sv
// Round-robin merge of NUM_FILTER buffered filter channels into one registered
// ready/valid stream tagged with the source channel.
module filter_arbiter_rr
    import filter_arbiter_rr_pkg::*;
#(
    parameter int unsigned NUM_FILTER = NUM_FILTER_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AF_MARGIN  = AF_MARGIN_DEF,
    parameter int unsigned CHAN_WIDTH = $clog2(NUM_FILTER)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FILTER-1:0]            in_valid,
    input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_data,
    output logic [NUM_FILTER-1:0]            almost_full,
    output logic [NUM_FILTER-1:0]            overflow,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CHAN_WIDTH-1:0]            out_chan,
    output logic [31:0]                      xfer_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = CHAN_WIDTH + 1;

    logic [NUM_FILTER-1:0] fifo_push;
    logic [NUM_FILTER-1:0] fifo_pop;
    logic [NUM_FILTER-1:0] fifo_empty;
    logic [NUM_FILTER-1:0] fifo_full;
    logic [NUM_FILTER-1:0] drop;
    logic [DATA_WIDTH-1:0] head [NUM_FILTER];
    logic [CW-1:0]         fifo_count [NUM_FILTER];

    logic [CHAN_WIDTH-1:0] ptr;
    logic [CHAN_WIDTH-1:0] ptr_nxt;
    logic [CHAN_WIDTH-1:0] gnt;
    logic [CHAN_WIDTH-1:0] scan_idx;
    logic [SW-1:0]         scan_sum;
    logic                  gnt_valid;
    logic                  load;

    for (genvar i = 0; i < int'(NUM_FILTER); i++) begin : g_chan
        assign fifo_push[i] = in_valid[i] && !fifo_full[i];
        assign drop[i]      = in_valid[i] && (fifo_count[i] == CW'(FIFO_DEPTH));

        filter_buffer_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .AF_MARGIN  (AF_MARGIN)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (fifo_push[i]),
            .din         (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop         (fifo_pop[i]),
            .dout        (head[i]),
            .empty       (fifo_empty[i]),
            .full        (fifo_full[i]),
            .almost_full (almost_full[i]),
            .count       (fifo_count[i])
        );
    end

    assign load = !out_valid || out_ready;

    // First non-empty channel scanning from ptr upward with wrap.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_FILTER; k++) begin
            scan_sum = SW'(ptr) + SW'(k);
            if (scan_sum >= SW'(NUM_FILTER)) scan_sum = scan_sum - SW'(NUM_FILTER);
            scan_idx = scan_sum[CHAN_WIDTH-1:0];
            if (!gnt_valid && !fifo_empty[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt       = scan_idx;
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        ptr_nxt  = ptr;
        if (load && gnt_valid) begin
            fifo_pop[gnt] = 1'b1;
            ptr_nxt       = (gnt == CHAN_WIDTH'(NUM_FILTER - 1)) ? '0 : gnt + CHAN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            overflow   <= '0;
            xfer_count <= '0;
        end else begin
            ptr      <= ptr_nxt;
            overflow <= overflow | drop;
            if (out_valid && out_ready) xfer_count <= xfer_count + 32'd1;
            if (load) begin
                out_valid <= gnt_valid;
                if (gnt_valid) begin
                    out_data <= head[gnt];
                    out_chan <= gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_filter_arbiter_rr.sv
// Directed bench for filter_arbiter_rr: reset, latency, fairness, overflow,
// stall hold and pointer wrap, with bench-computed expectations.
module tb_filter_arbiter_rr;

    localparam int unsigned NF = 4;
    localparam int unsigned DW = 96;
    localparam int unsigned FD = 8;

    logic             clk;
    logic             rst;
    logic [NF-1:0]    in_valid;
    logic [NF*DW-1:0] in_data;
    logic [NF-1:0]    almost_full;
    logic [NF-1:0]    overflow;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_chan;
    logic [31:0]      xfer_count;

    int n_checks = 0;
    int n_pass   = 0;

    filter_arbiter_rr #(
        .NUM_FILTER (NF),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (FD),
        .AF_MARGIN  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .almost_full (almost_full),
        .overflow    (overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .xfer_count  (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] v);
        in_data[ch*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_chan;
    logic          prev_stall;
    logic          rdy;
    logic          found;
    int            fidx;
    int            pushed;
    int            received;
    int            ch;

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset values after 3 cycles of rst.
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", 128'(out_data), 128'(0));
        check("rst_chan", 128'(out_chan), 128'(0));
        check("rst_af", 128'(almost_full), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_xfer", 128'(xfer_count), 128'(0));

        // Single-channel latency on channel 2.
        in_valid[2] = 1'b1;
        set_data(2, DW'('hA5));
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        check("lat_no_bypass", 128'(out_valid), 128'(0));
        tick();
        check("lat_valid", 128'(out_valid), 128'(1));
        check("lat_data", 128'(out_data), 128'('hA5));
        check("lat_chan", 128'(out_chan), 128'(2));
        tick();
        check("lat_xfer", 128'(xfer_count), 128'(1));
        check("lat_drained", 128'(out_valid), 128'(0));

        // Reset mid-stream discards everything.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            set_data(0, DW'(32'h0BAD_0000 + k));
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = '0;
        check("mrst_valid", 128'(out_valid), 128'(0));
        check("mrst_xfer", 128'(xfer_count), 128'(0));
        check("mrst_af", 128'(almost_full), 128'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mrst_no_stale", 128'(out_valid), 128'(0));
        end

        // Fairness: 4 records preloaded per channel, drained round-robin.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = '1;
            for (int c = 0; c < 4; c++) set_data(c, DW'(32'h100 * c + k));
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("rr_valid", 128'(out_valid), 128'(1));
            check("rr_chan", 128'(out_chan), 128'(j % 4));
            check("rr_data", 128'(out_data), 128'(32'h100 * (j % 4) + j / 4));
            tick();
        end
        check("rr_empty", 128'(out_valid), 128'(0));
        check("rr_xfer", 128'(xfer_count), 128'(16));

        // Back-pressure and overflow on channel 1 with the output stage occupied.
        do_reset();
        in_valid[0] = 1'b1;
        set_data(0, DW'('hAA));
        tick();
        in_valid = '0;
        tick();
        check("bp_hold_chan", 128'({out_valid, out_chan}), 128'({1'b1, 2'd0}));
        for (int k = 1; k <= 10; k++) begin
            in_valid[1] = 1'b1;
            set_data(1, DW'(32'h10 + k - 1));
            tick();
            check("bp_af_ovf", 128'({almost_full[1], overflow[1]}), 128'({k >= 6, k >= 9}));
        end
        in_valid  = '0;
        out_ready = 1'b1;
        check("bp_first", 128'({out_valid, out_chan, out_data}), 128'({1'b1, 2'd0, DW'('hAA)}));
        tick();
        for (int j = 0; j < 8; j++) begin
            check("bp_drain", 128'({out_valid, out_chan, out_data}), 128'({1'b1, 2'd1, DW'(32'h10 + j)}));
            tick();
        end
        check("bp_done", 128'(out_valid), 128'(0));
        check("bp_ovf_sticky", 128'(overflow), 128'(4'b0010));
        check("bp_af_clear", 128'(almost_full), 128'(0));

        // Random stall over 100 records; per-channel order checked against a scoreboard.
        do_reset();
        pushed     = 0;
        received   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_chan  = '0;
        for (int cyc = 0; cyc < 3000 && received < 100; cyc++) begin
            if (prev_stall)
                check("stall_hold", 128'({out_valid, out_chan, out_data}), 128'({1'b1, prev_chan, prev_data}));
            rdy       = 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (out_valid && rdy) begin
                found = 1'b0;
                fidx  = 0;
                exp_d = '1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (!found && sb[i][23:16] == 8'(out_chan)) begin
                        found = 1'b1;
                        fidx  = i;
                        exp_d = sb[i];
                    end
                end
                if (found) sb.delete(fidx);
                check("stall_data", 128'(out_data), 128'(exp_d));
                received++;
            end
            prev_stall = out_valid && !rdy;
            prev_data  = out_data;
            prev_chan  = out_chan;
            in_valid   = '0;
            if (pushed < 100) begin
                ch = int'($urandom_range(0, 3));
                if (!almost_full[ch]) begin
                    in_valid[ch] = 1'b1;
                    set_data(ch, DW'((ch << 16) | pushed));
                    sb.push_back(DW'((ch << 16) | pushed));
                    pushed++;
                end
            end
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b0;
        check("stall_count", 128'(received), 128'(100));
        check("stall_xfer", 128'(xfer_count), 128'(100));
        check("stall_empty", 128'(out_valid), 128'(0));

        // Pointer wrap: 3*FIFO_DEPTH records through channel 3 alone.
        do_reset();
        pushed   = 0;
        received = 0;
        for (int cyc = 0; cyc < 500 && received < 24; cyc++) begin
            rdy       = (cyc % 3 != 0);
            out_ready = rdy;
            if (out_valid && rdy) begin
                check("wrap_chan", 128'(out_chan), 128'(3));
                check("wrap_data", 128'(out_data), 128'(32'h300 + received));
                received++;
            end
            in_valid = '0;
            if (pushed < 24 && !almost_full[3]) begin
                in_valid[3] = 1'b1;
                set_data(3, DW'(32'h300 + pushed));
                pushed++;
            end
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b0;
        check("wrap_count", 128'(received), 128'(24));
        check("wrap_ovf", 128'(overflow), 128'(0));
        check("wrap_xfer", 128'(xfer_count), 128'(24));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
